// File: rtl/fetch_buffer_if.sv
// fetch_buffer_if: bundles the fetch-issue, imem-response, flush and decode-side handshake
// signals of the fetch buffer.
//   slave  : view taken by fetch_buffer (consumes issue/response/flush/out_ready, drives the rest)
//   master : view taken by the surrounding fetch/imem/decode logic
// Signals:
//   fetch_valid/fetch_pc/fetch_pc_next -> read being issued, fetch_ready <- issue accepted
//   imem_resp/imem_rdata               -> instruction word returned by imem
//   flush                              -> redirect, drop queue and in-flight read
//   out_valid/out_inst/out_pc/out_pc_next <- head entry toward decode, out_ready -> consumed
//   busy                               <- a read is outstanding
interface fetch_buffer_if;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_next;
    logic        fetch_ready;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc_next;
    logic        busy;

    modport slave (
        input  fetch_valid, fetch_pc, fetch_pc_next, imem_resp, imem_rdata, flush, out_ready,
        output fetch_ready, out_valid, out_inst, out_pc, out_pc_next, busy
    );

    modport master (
        output fetch_valid, fetch_pc, fetch_pc_next, imem_resp, imem_rdata, flush, out_ready,
        input  fetch_ready, out_valid, out_inst, out_pc, out_pc_next, busy
    );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: decouples instruction fetch from decode.
// Tracks the single outstanding imem read, captures the returned word together with the PC and
// next-PC it was issued for, and queues the result in a DEPTH-entry FIFO toward decode.
// A flush empties the queue; a read still in flight at that point is marked stale and its
// response is dropped.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - fetch_buffer_if.slave (issue, imem response, flush, decode handshake, busy)
module fetch_buffer #(
    parameter int unsigned DEPTH = 2  // power of two, >= 2
) (
    input logic           clk,
    input logic           rst,
    fetch_buffer_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_next;
    } entry_t;

    typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

    state_e        state_q;
    logic [31:0]   pend_pc_q;
    logic [31:0]   pend_pc_next_q;
    entry_t        mem_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;

    logic          push;
    logic          pop;
    logic          fire;
    logic          issue_state;
    logic          slot_free;
    logic [CW:0]   level;

    // A new read is only accepted if the queue will still have room for its response after
    // this cycle's push/pop, so a push can never find the queue full.
    always_comb begin
        push        = (state_q == StWait) & bus.imem_resp & ~bus.flush;
        pop         = bus.out_valid & bus.out_ready & ~bus.flush;
        level       = {1'b0, count_q} + (CW + 1)'(push) - (CW + 1)'(pop);
        slot_free   = 32'(level) < DEPTH;
        issue_state = (state_q == StIdle) | ((state_q == StWait) & bus.imem_resp);
        bus.fetch_ready = ~rst & ~bus.flush & issue_state & slot_free;
        fire        = bus.fetch_valid & bus.fetch_ready;
    end

    assign bus.out_valid   = (count_q != '0);
    assign bus.out_inst    = mem_q[head_q].inst;
    assign bus.out_pc      = mem_q[head_q].pc;
    assign bus.out_pc_next = mem_q[head_q].pc_next;
    assign bus.busy        = (state_q != StIdle);

    // Read-tracking FSM plus the PC pair of the outstanding read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            pend_pc_q      <= '0;
            pend_pc_next_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fire) begin
                        pend_pc_q      <= bus.fetch_pc;
                        pend_pc_next_q <= bus.fetch_pc_next;
                        state_q        <= StWait;
                    end
                end
                StWait: begin
                    if (bus.flush) begin
                        // Read still in flight becomes stale and must be absorbed in StDrain.
                        state_q <= bus.imem_resp ? StIdle : StDrain;
                    end else if (bus.imem_resp) begin
                        if (fire) begin
                            pend_pc_q      <= bus.fetch_pc;
                            pend_pc_next_q <= bus.fetch_pc_next;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StDrain: begin
                    if (bus.imem_resp) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Entry storage is reset too so the decode-side fields read zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus.flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[tail_q] <= '{inst: bus.imem_rdata, pc: pend_pc_q, pc_next: pend_pc_next_q};
                tail_q        <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            if (push & ~pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop & ~push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed scenarios followed by randomized traffic, all checked against a
// queue-based reference model of the fetch buffer.
module tb_fetch_buffer;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] BASE  = 32'h1eceb000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_buffer_if bus ();

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_next;
    } ent_t;

    // Reference model: queue toward decode plus status of the single imem read.
    ent_t        m_q[$];
    int          m_rd;       // 0: no read, 1: live read, 2: stale read (after flush)
    logic [31:0] m_pc;
    logic [31:0] m_pcn;
    logic [31:0] cur_pc;     // address the fetch stage offers next
    logic [31:0] cur_pcn;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rd  = 0;
        m_pc  = '0;
        m_pcn = '0;
    endtask

    // One clock: drive at negedge, compare 1 time unit later, then advance the model.
    task automatic step(input logic fv, input logic resp, input logic [31:0] rdata,
                        input logic fl, input logic ordy);
        logic push, pop, exp_ready, fire;
        int   level;
        @(negedge clk);
        bus.fetch_valid   = fv;
        bus.fetch_pc      = cur_pc;
        bus.fetch_pc_next = cur_pcn;
        bus.imem_resp     = resp;
        bus.imem_rdata    = rdata;
        bus.flush         = fl;
        bus.out_ready     = ordy;
        #1;
        push      = (m_rd == 1) && resp && !fl;
        pop       = (m_q.size() != 0) && ordy && !fl;
        level     = m_q.size() + (push ? 1 : 0) - (pop ? 1 : 0);
        exp_ready = !fl && (m_rd == 0 || (m_rd == 1 && resp)) && (level < DEPTH);
        fire      = fv && exp_ready;
        check("fetch_ready", 32'(bus.fetch_ready), 32'(exp_ready));
        check("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
        check("busy", 32'(bus.busy), 32'(m_rd != 0));
        if (m_q.size() != 0) begin
            check("out_inst", bus.out_inst, m_q[0].inst);
            check("out_pc", bus.out_pc, m_q[0].pc);
            check("out_pc_next", bus.out_pc_next, m_q[0].pc_next);
        end
        if (fl) begin
            m_q.delete();
            if (m_rd == 1) m_rd = resp ? 0 : 2;
            else if (m_rd == 2 && resp) m_rd = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back('{rdata, m_pc, m_pcn});
            if (m_rd != 0 && resp) m_rd = 0;
            if (fire) begin
                m_rd    = 1;
                m_pc    = cur_pc;
                m_pcn   = cur_pcn;
                cur_pc  = cur_pcn;
                cur_pcn = cur_pcn + 32'd4;
            end
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus.fetch_valid   = 1'b1;
        bus.fetch_pc      = '0;
        bus.fetch_pc_next = '0;
        bus.imem_resp     = 1'b0;
        bus.imem_rdata    = '0;
        bus.flush         = 1'b0;
        bus.out_ready     = 1'b0;
        cur_pc            = BASE;
        cur_pcn           = BASE + 32'd4;
        model_reset();
        #12;
        check("rst_fetch_ready", 32'(bus.fetch_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_out_inst", bus.out_inst, 32'd0);
        check("rst_out_pc", bus.out_pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.fetch_valid = 1'b0;

        // Single fetch: issue T0, response T1, visible T2, popped T2 so gone at T3.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h00000013, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("single_valid", 32'(bus.out_valid), 32'd1);
        check("single_inst", bus.out_inst, 32'h00000013);
        check("single_pc", bus.out_pc, BASE);
        check("single_pc_next", bus.out_pc_next, BASE + 32'd4);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("single_popped", 32'(bus.out_valid), 32'd0);

        // Back-to-back streaming with 1-cycle imem and decode always ready.
        cur_pc  = BASE;
        cur_pcn = BASE + 32'd4;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, k > 0, 32'ha0000000 + 32'(k), 1'b0, 1'b1);
            check("stream_ready", 32'(bus.fetch_ready), 32'd1);
            if (k >= 2) check("stream_pc", bus.out_pc, BASE + 32'(4 * (k - 2)));
        end
        step(1'b0, 1'b1, 32'ha0000008, 1'b0, 1'b1);
        check("stream_pc", bus.out_pc, BASE + 32'd24);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("stream_pc", bus.out_pc, BASE + 32'd28);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Backpressure: decode stalled until the queue fills, then released.
        cur_pc  = BASE;
        cur_pcn = BASE + 32'd4;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, m_rd == 1, 32'hb0000000 + 32'(k), 1'b0, 1'b0);
            if (k >= 2) begin
                check("bp_ready_low", 32'(bus.fetch_ready), 32'd0);
                check("bp_head_pc", bus.out_pc, BASE);
            end
        end
        for (int k = 0; k < 6; k++) begin
            step(1'b1, m_rd == 1, 32'hb0000010 + 32'(k), 1'b0, 1'b1);
            if (k == 0) check("bp_resume", 32'(bus.fetch_ready), 32'd1);
        end
        for (int k = 0; k < 4; k++) step(1'b0, m_rd == 1, 32'hb0000020, 1'b0, 1'b1);

        // Flush while waiting with no response: drain state absorbs the late response.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check("drain_busy", 32'(bus.busy), 32'd1);
        check("drain_ready", 32'(bus.fetch_ready), 32'd0);
        step(1'b1, 1'b1, 32'hdeadbeef, 1'b0, 1'b1);
        check("drain_resp_ready", 32'(bus.fetch_ready), 32'd0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check("drain_done_ready", 32'(bus.fetch_ready), 32'd1);
        check("drain_no_output", 32'(bus.out_valid), 32'd0);
        step(1'b0, 1'b1, 32'hc0000001, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Flush coincident with a response while one entry is queued.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'hc0000002, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hc0000003, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("flush_resp_valid", 32'(bus.out_valid), 32'd0);
        check("flush_resp_busy", 32'(bus.busy), 32'd0);

        // Asynchronous reset mid-read with an entry queued.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'hc0000004, 1'b0, 1'b0);
        @(negedge clk);
        bus.fetch_valid = 1'b0;
        bus.imem_resp   = 1'b0;
        #1;
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_fetch_ready", 32'(bus.fetch_ready), 32'd0);
        check("arst_out_inst", bus.out_inst, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, 32'hdeadbeef, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("late_resp_ignored", 32'(bus.out_valid), 32'd0);

        // Randomized traffic: stalls, branches, redirects and stray responses.
        for (int k = 0; k < 800; k++) begin
            logic fv, resp, fl, ordy;
            fv   = $urandom_range(0, 9) < 7;
            resp = (m_rd != 0) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 29) == 0);
            fl   = $urandom_range(0, 19) == 0;
            ordy = $urandom_range(0, 9) < 6;
            if ($urandom_range(0, 3) == 0) cur_pcn = $urandom & 32'hffff_fffc;
            if (fl) begin
                cur_pc  = $urandom & 32'hffff_fffc;
                cur_pcn = cur_pc + 32'd4;
            end
            step(fv, resp, $urandom, fl, ordy);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
